ps2_key_decoder: RTL and testbench
==================================

// Module: ps2_key_decoder
// PURPOSE
//  Device-to-host PS/2 keyboard receiver. Produces the 11-bit ps2_key event word
//  {toggle, pressed, extended, code[7:0]} that the core consumes from hps_io.
//  Lets the CBM-II keyboard matrix be driven from a physical PS/2 keyboard on the
//  user port, with the same event format and semantics as the HPS path.
// PARAMETERS
//  CLK_HZ      32000000  clk frequency in Hz; used only for the timeout count
//  FILTER_LEN  8         cycles a synchronised PS/2 clock level must hold before it is accepted
//  TIMEOUT_US  2000      maximum gap between falling edges inside a frame before abort
// PORTS
//  clk       in   1   system clock (clk_sys domain)
//  reset_n   in   1   asynchronous reset, active-low
//  ps2_clk   in   1   raw PS/2 clock from pin; asynchronous
//  ps2_data  in   1   raw PS/2 data from pin; asynchronous
//  ps2_key   out  11  [10] toggles per event, [9] 1=make/0=break, [8] E0 prefix, [7:0] scan code
//  err       out  1   one-cycle pulse on a parity, start or stop error, or on a timeout
// BEHAVIOUR
//  Reset (async, reset_n=0):
//   - ps2_key=0, err=0; FSM in IDLE; ext/rel flags and skip count cleared.
//   - Filter output is preset to 1. Bit counter and timeout counter are 0.
//  Input conditioning:
//   - 2-FF synchroniser on both pins.
//   - Filtered clock changes only after FILTER_LEN consecutive equal samples.
//   - A fall strobe (1 cycle) marks a 1->0 change of the filtered clock.
//   - Data is sampled at the strobe from the synchronised data line.
//  Frame FSM (advances only on the fall strobe, except for timeout):
//   - IDLE: data=0 -> DATA with bit count 0. data=1 -> remain in IDLE, no error (noise).
//   - DATA: shift the sample in LSB first. After the 8th bit -> PARITY.
//   - PARITY: store the sample -> STOP.
//   - STOP: if data=1 and the 9 bits {parity, byte} have odd parity -> byte strobe.
//     Otherwise -> err pulse. Both cases -> IDLE.
//   - Timeout: if not IDLE and TIMEOUT = CLK_HZ/1e6*TIMEOUT_US cycles pass with no
//     fall strobe, the FSM returns to IDLE, the partial frame is dropped and err pulses.
//     The counter clears on every strobe.
//   - If the timeout expiry and a strobe land on the same cycle, the strobe wins.
//  Byte handling (one cycle after the byte strobe):
//   - Skip count > 0: decrement it and discard the byte.
//   - E1: skip count <- 7, which swallows the Pause sequence. Flags are cleared and no event is produced.
//   - E0: ext <- 1. F0: rel <- 1.
//   - FA, AA, EE, FE, 00, FF: discarded, flags cleared.
//   - Any other byte:
//     - ps2_key <= {~ps2_key[10], ~rel, ext, byte}
//     - ext <= 0, rel <= 0
//  Errors: any err pulse also clears ext and rel, so a prefix never attaches to an
//   unrelated code. Skip count is kept.
//  Latency:
//   - The raw stop-bit fall to the ps2_key update takes 2 + FILTER_LEN + 2 clk cycles, fixed.
//   - ps2_key holds its value between events.
//   - The consumer detects new events only by a change of bit 10.
//  err does not assert in the same cycle as a ps2_key update for the same frame.
// TESTING
//  T1: Frame 0x1C with correct parity, 12.5 kHz PS/2 clock -> ps2_key=11'h61C (toggle 1),
//      err stays 0.
//  T2: T1 then F0,1C -> after the F0 ps2_key is unchanged. After the 1C, ps2_key=11'h01C
//      (toggle 0, pressed 0).
//  T3: E0,75 then E0,F0,75 -> 11'h775, then 11'h175. Prefix flags are clear afterwards.
//  T4: Frame 0x1C with a flipped parity bit -> err pulses exactly 1 cycle and ps2_key is
//      unchanged. The next valid 0x1C -> 11'h61C, not extended.
//  T5: Start + 5 bits then clock held high for more than TIMEOUT -> err pulse, FSM back in IDLE.
//      A following full 0x29 frame decodes as 11'h629.
//  T6: Pause sequence E1 14 77 E1 F0 14 F0 77 -> no ps2_key change. A following 0x1C
//      decodes normally.
//  T7: reset_n low mid-frame (after bit 3) -> outputs 0 immediately.
//      After release a clean 0x1C -> 11'h61C.

Source files
------------

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver producing the 11-bit ps2_key event word.
// Conditions the raw pins, frames bytes and folds prefixes into events.
module ps2_key_decoder #(
  parameter int CLK_HZ     = 32000000,
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT_US = 2000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [10:0] ps2_key,
  output logic        err
);

  localparam int TIMEOUT = CLK_HZ / 1000000 * TIMEOUT_US;
  localparam int TW      = $clog2(TIMEOUT + 1);
  localparam int FW      = $clog2(FILTER_LEN + 1);

  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  localparam logic [FW-1:0] FL_LAST = FW'(FILTER_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  logic          r_c1;
  logic          r_c2;
  logic          r_d1;
  logic          r_d2;
  logic          r_filt;
  logic [FW-1:0] r_fcnt;
  logic          r_fall;

  state_t        r_state;
  logic [2:0]    r_bcnt;
  logic [7:0]    r_shift;
  logic          r_par;
  logic [TW-1:0] r_tcnt;
  logic          r_bstb;
  logic [7:0]    r_byte;
  logic          r_err;

  logic          r_ext;
  logic          r_rel;
  logic [2:0]    r_skip;
  logic [10:0]   r_key;

  logic          w_par_ok;

  assign w_par_ok = ^{r_par, r_shift};
  assign ps2_key  = r_key;
  assign err      = r_err;

  // Two-stage synchronisers on both raw pins (idle-high bus)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_c1 <= 1'b1;
      r_c2 <= 1'b1;
      r_d1 <= 1'b1;
      r_d2 <= 1'b1;
    end else begin
      r_c1 <= ps2_clk;
      r_c2 <= r_c1;
      r_d1 <= ps2_data;
      r_d2 <= r_d1;
    end
  end

  // Deglitch the clock: accept a new level after FILTER_LEN samples
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_filt <= 1'b1;
      r_fcnt <= '0;
      r_fall <= 1'b0;
    end else if (r_c2 != r_filt) begin
      if (r_fcnt == FL_LAST) begin
        r_filt <= r_c2;
        r_fcnt <= '0;
        r_fall <= ~r_c2;
      end else begin
        r_fcnt <= r_fcnt + 1'b1;
        r_fall <= 1'b0;
      end
    end else begin
      r_fcnt <= '0;
      r_fall <= 1'b0;
    end
  end

  // Frame FSM: start, 8 data bits LSB first, odd parity, stop
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_bcnt  <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_tcnt  <= '0;
      r_bstb  <= 1'b0;
      r_byte  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_bstb <= 1'b0;
      r_err  <= 1'b0;
      if (r_fall) begin
        r_tcnt <= '0;
        unique case (r_state)
          S_IDLE: begin
            if (!r_d2) begin
              r_state <= S_DATA;
              r_bcnt  <= '0;
            end
          end
          S_DATA: begin
            r_shift <= {r_d2, r_shift[7:1]};
            r_bcnt  <= r_bcnt + 3'd1;
            if (r_bcnt == 3'd7) r_state <= S_PAR;
          end
          S_PAR: begin
            r_par   <= r_d2;
            r_state <= S_STOP;
          end
          S_STOP: begin
            r_state <= S_IDLE;
            if (r_d2 && w_par_ok) begin
              r_bstb <= 1'b1;
              r_byte <= r_shift;
            end else begin
              r_err <= 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end else if (r_state != S_IDLE) begin
        if (r_tcnt == TO_LAST) begin
          r_state <= S_IDLE;
          r_tcnt  <= '0;
          r_err   <= 1'b1;
        end else begin
          r_tcnt <= r_tcnt + 1'b1;
        end
      end else begin
        r_tcnt <= '0;
      end
    end
  end

  // Fold prefixes into events; swallow Pause and protocol replies
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ext  <= 1'b0;
      r_rel  <= 1'b0;
      r_skip <= '0;
      r_key  <= '0;
    end else if (r_err) begin
      r_ext <= 1'b0;
      r_rel <= 1'b0;
    end else if (r_bstb) begin
      if (r_skip != 3'd0) begin
        r_skip <= r_skip - 3'd1;
      end else begin
        case (r_byte)
          8'hE1: begin
            r_skip <= 3'd7;
            r_ext  <= 1'b0;
            r_rel  <= 1'b0;
          end
          8'hE0: r_ext <= 1'b1;
          8'hF0: r_rel <= 1'b1;
          8'hFA, 8'hAA, 8'hEE,
          8'hFE, 8'h00, 8'hFF: begin
            r_ext <= 1'b0;
            r_rel <= 1'b0;
          end
          default: begin
            r_key <= {~r_key[10], ~r_rel, r_ext, r_byte};
            r_ext <= 1'b0;
            r_rel <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder.
// Drives PS/2 frames and checks event words, err pulses and latency.
module tb_ps2_key_decoder;

  localparam int CLK_HZ  = 1000000;
  localparam int FLEN    = 8;
  localparam int TO_US   = 200;
  localparam int TIMEOUT = CLK_HZ / 1000000 * TO_US;
  localparam int HALF    = 40;

  logic        clk;
  logic        reset_n;
  logic        ps2_clk;
  logic        ps2_data;
  logic [10:0] ps2_key;
  logic        err;

  int n_chk;
  int n_err;
  int cyc;
  int err_cnt;
  int fall_cyc;
  int chg_cyc;
  int e0;
  logic [10:0] key_q;

  ps2_key_decoder #(
    .CLK_HZ    (CLK_HZ),
    .FILTER_LEN(FLEN),
    .TIMEOUT_US(TO_US)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .ps2_key (ps2_key),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (err) err_cnt++;
    if (ps2_key !== key_q) begin
      key_q   = ps2_key;
      chg_cyc = cyc;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [10:0] obs,
                     input logic [10:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic ps2_bit(input logic b);
    @(negedge clk);
    ps2_data = b;
    repeat (HALF) @(negedge clk);
    ps2_clk  = 1'b0;
    fall_cyc = cyc;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send(input logic [7:0] b, input bit bad_par = 0,
                      input bit bad_stop = 0);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ bad_par);
    ps2_bit(~bad_stop);
    ps2_data = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n  = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    n_chk    = 0;
    n_err    = 0;
    cyc      = 0;
    err_cnt  = 0;
    fall_cyc = 0;
    chg_cyc  = 0;
    reset_n  = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_key", ps2_key, 11'h000);
    chk("rst_err", {10'd0, err}, 11'h000);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // T1 / latency
    e0 = err_cnt;
    send(8'h1C);
    chk("t1_key", ps2_key, 11'h61C);
    chk("t1_err", 11'(err_cnt - e0), 11'd0);
    chk("t1_lat", 11'(chg_cyc - fall_cyc), 11'(2 + FLEN + 2));

    // T2
    send(8'hF0);
    chk("t2_f0", ps2_key, 11'h61C);
    send(8'h1C);
    chk("t2_brk", ps2_key, 11'h01C);

    // T3
    do_reset();
    send(8'hE0);
    send(8'h75);
    chk("t3_mk", ps2_key, 11'h775);
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    chk("t3_brk", ps2_key, 11'h175);
    send(8'h1C);
    chk("t3_clr", ps2_key, 11'h61C);

    // T4 parity error, prefix must be dropped
    do_reset();
    e0 = err_cnt;
    send(8'hE0);
    send(8'h1C, 1'b1);
    chk("t4_err", 11'(err_cnt - e0), 11'd1);
    chk("t4_key", ps2_key, 11'h000);
    send(8'h1C);
    chk("t4_next", ps2_key, 11'h61C);

    // stop-bit error
    e0 = err_cnt;
    send(8'h29, 1'b0, 1'b1);
    chk("stop_err", 11'(err_cnt - e0), 11'd1);
    chk("stop_key", ps2_key, 11'h61C);

    // T5 timeout
    do_reset();
    e0 = err_cnt;
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_data = 1'b1;
    repeat (TIMEOUT + 50) @(negedge clk);
    chk("t5_err", 11'(err_cnt - e0), 11'd1);
    chk("t5_key", ps2_key, 11'h000);
    e0 = err_cnt;
    send(8'h29);
    chk("t5_next", ps2_key, 11'h629);
    chk("t5_noerr", 11'(err_cnt - e0), 11'd0);

    // T6 Pause
    do_reset();
    e0 = err_cnt;
    send(8'hE1);
    send(8'h14);
    send(8'h77);
    send(8'hE1);
    send(8'hF0);
    send(8'h14);
    send(8'hF0);
    send(8'h77);
    chk("t6_key", ps2_key, 11'h000);
    chk("t6_err", 11'(err_cnt - e0), 11'd0);
    send(8'h1C);
    chk("t6_next", ps2_key, 11'h61C);

    // discarded reply byte clears a pending prefix
    send(8'hE0);
    send(8'hAA);
    chk("aa_key", ps2_key, 11'h61C);
    send(8'h1C);
    chk("aa_next", ps2_key, 11'h21C);

    // short clock glitch and idle noise are ignored
    e0 = err_cnt;
    @(negedge clk);
    ps2_data = 1'b0;
    ps2_clk  = 1'b0;
    repeat (FLEN - 2) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (20) @(negedge clk);
    ps2_data = 1'b1;
    ps2_bit(1'b1);
    repeat (20) @(negedge clk);
    send(8'h75);
    chk("noise_key", ps2_key, 11'h675);
    chk("noise_err", 11'(err_cnt - e0), 11'd0);

    // T7 reset mid-frame
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("t7_key", ps2_key, 11'h000);
    chk("t7_err", {10'd0, err}, 11'h000);
    repeat (3) @(negedge clk);
    ps2_data = 1'b1;
    ps2_clk  = 1'b1;
    reset_n  = 1'b1;
    repeat (5) @(negedge clk);
    send(8'h1C);
    chk("t7_next", ps2_key, 11'h61C);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
